// File: rtl/fpu_out_pkg.sv
// ---------------------------------------------------------------------------
// fpu_out_pkg
// Shared definitions for the FPU result queue: default result/flag widths,
// the packed {result, flags} entry width and the occupancy-counter width.
// No ports (package).
// ---------------------------------------------------------------------------
package fpu_out_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_FLAG_W = 4;

    // One queue entry holds the result word with its flags packed in the LSBs.
    function automatic int entry_w(input int data_w, input int flag_w);
        return data_w + flag_w;
    endfunction

    // The occupancy counter must represent 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fpu_result_queue_mem.sv
// ---------------------------------------------------------------------------
// fpu_result_queue_mem
// DEPTH x ENTRY_W register array used as the FPU result queue storage.
// Synchronous write, asynchronous read, synchronous clear on reset.
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high clear of every slot
//   wr_en    in   write wr_data into slot wr_addr at the rising edge
//   wr_addr  in   write slot index
//   wr_data  in   entry to store
//   rd_addr  in   read slot index
//   rd_data  out  contents of slot rd_addr (combinational from registers)
// ---------------------------------------------------------------------------
module fpu_result_queue_mem
    import fpu_out_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = entry_w(DEFAULT_DATA_W, DEFAULT_FLAG_W),
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fpu_result_queue.sv
// ---------------------------------------------------------------------------
// fpu_result_queue
// DEPTH-entry FIFO of {result, flags} between the FPU datapath and the host
// register interface. Presents the head entry with a ready flag, occupancy
// count, full flag, sticky overflow and a registered level interrupt.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   result, flags     FPU result and exception flags, captured on doorbell
//   fpu_doorbell_r_i  push strobe (one entry per cycle high)
//   fpu_rd_ack        host consumed head entry (pop)
//   fpu_int_en        interrupt enable
//   fpu_ovf_clr       clears sticky overflow
//   fpu_ready         queue non-empty, head valid
//   fpu_output        head result
//   fpu_output_flags  head flags
//   fpu_count         occupancy 0..DEPTH
//   fpu_full          occupancy == DEPTH
//   fpu_overflow      sticky: a push was dropped while full
//   fpu_irq           registered level interrupt
// ---------------------------------------------------------------------------
module fpu_result_queue
    import fpu_out_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FLAG_W     = DEFAULT_FLAG_W,
    parameter int DEPTH      = 4,
    parameter int IRQ_THRESH = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           result,
    input  logic [FLAG_W-1:0]           flags,
    input  logic                        fpu_doorbell_r_i,
    input  logic                        fpu_rd_ack,
    input  logic                        fpu_int_en,
    input  logic                        fpu_ovf_clr,
    output logic                        fpu_ready,
    output logic [DATA_W-1:0]           fpu_output,
    output logic [FLAG_W-1:0]           fpu_output_flags,
    output logic [count_w(DEPTH)-1:0]   fpu_count,
    output logic                        fpu_full,
    output logic                        fpu_overflow,
    output logic                        fpu_irq
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int CNT_W   = count_w(DEPTH);
    localparam int ENTRY_W = entry_w(DATA_W, FLAG_W);

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(IRQ_THRESH);

    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               irq_q, irq_d;
    logic               push_ok, pop_ok, is_full;
    logic [ENTRY_W-1:0] head_entry;

    // A pop frees a slot in the same cycle, so a push into a full queue is
    // accepted whenever the host is also acknowledging the head.
    always_comb begin
        is_full  = (count_q == CNT_FULL);
        pop_ok   = fpu_rd_ack && (count_q != '0);
        push_ok  = fpu_doorbell_r_i && (!is_full || pop_ok);

        wr_ptr_d = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A new drop wins over a clear arriving in the same cycle.
        overflow_d = overflow_q;
        if (fpu_doorbell_r_i && is_full && !pop_ok) begin
            overflow_d = 1'b1;
        end else if (fpu_ovf_clr) begin
            overflow_d = 1'b0;
        end

        // Based on post-update occupancy so the interrupt rises together
        // with the entry that crosses the threshold.
        irq_d = fpu_int_en && (count_d >= CNT_THRESH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

    fpu_result_queue_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr_q),
        .wr_data ({result, flags}),
        .rd_addr (rd_ptr_q),
        .rd_data (head_entry)
    );

    assign fpu_output       = head_entry[ENTRY_W-1:FLAG_W];
    assign fpu_output_flags = head_entry[FLAG_W-1:0];
    assign fpu_ready        = (count_q != '0);
    assign fpu_full         = is_full;
    assign fpu_count        = count_q;
    assign fpu_overflow     = overflow_q;
    assign fpu_irq          = irq_q;

endmodule

// File: tb/tb_fpu_result_queue.sv
// ---------------------------------------------------------------------------
// tb_fpu_result_queue
// Scoreboard bench for fpu_result_queue (DEPTH=4, IRQ_THRESH=2). A queue-based
// reference model produces the expected output snapshot after every clock;
// a separate monitor pops snapshots and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_fpu_result_queue;

    localparam int DW     = 32;
    localparam int FW     = 4;
    localparam int DEPTH  = 4;
    localparam int THRESH = 2;
    localparam int CW     = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] result = '0;
    logic [FW-1:0] flags = '0;
    logic          doorbell = 1'b0;
    logic          rd_ack = 1'b0;
    logic          int_en = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          fpu_ready;
    logic [DW-1:0] fpu_output;
    logic [FW-1:0] fpu_output_flags;
    logic [CW-1:0] fpu_count;
    logic          fpu_full;
    logic          fpu_overflow;
    logic          fpu_irq;

    typedef struct {
        logic [DW-1:0] data;
        logic [FW-1:0] flg;
    } entry_t;

    typedef struct {
        logic          ready;
        logic [DW-1:0] data;
        logic [FW-1:0] flg;
        int            count;
        logic          full;
        logic          ovf;
        logic          irq;
        logic          check_head;
    } snap_t;

    entry_t model_q[$];
    snap_t  exp_q[$];
    logic   model_ovf = 1'b0;
    logic   model_irq = 1'b0;
    logic   zero_head = 1'b0;
    int     tests_run = 0;
    int     tests_failed = 0;

    fpu_result_queue #(
        .DATA_W     (DW),
        .FLAG_W     (FW),
        .DEPTH      (DEPTH),
        .IRQ_THRESH (THRESH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .result           (result),
        .flags            (flags),
        .fpu_doorbell_r_i (doorbell),
        .fpu_rd_ack       (rd_ack),
        .fpu_int_en       (int_en),
        .fpu_ovf_clr      (ovf_clr),
        .fpu_ready        (fpu_ready),
        .fpu_output       (fpu_output),
        .fpu_output_flags (fpu_output_flags),
        .fpu_count        (fpu_count),
        .fpu_full         (fpu_full),
        .fpu_overflow     (fpu_overflow),
        .fpu_irq          (fpu_irq)
    );

    always #5 clk = ~clk;

    // Single comparison; every call is one counted test.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the reference model and
    // queue the snapshot the DUT should present afterwards.
    task automatic applyStimulus(input logic rst, input logic db, input logic [DW-1:0] res,
                                 input logic [FW-1:0] flg, input logic ack,
                                 input logic ien, input logic clr);
        bit     pop, push, full;
        entry_t e;
        snap_t  s;
        @(negedge clk);
        reset = rst; doorbell = db; result = res; flags = flg;
        rd_ack = ack; int_en = ien; ovf_clr = clr;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_irq = 1'b0;
            zero_head = 1'b1;
        end else begin
            full = (model_q.size() == DEPTH);
            pop  = ack && (model_q.size() > 0);
            push = db && (!full || pop);
            if (db && full && !pop) model_ovf = 1'b1;
            else if (clr)           model_ovf = 1'b0;
            if (pop) void'(model_q.pop_front());
            if (push) begin
                e.data = res; e.flg = flg;
                model_q.push_back(e);
                zero_head = 1'b0;
            end
            model_irq = ien && (model_q.size() >= THRESH);
        end
        s.ready = (model_q.size() != 0);
        s.count = model_q.size();
        s.full  = (model_q.size() == DEPTH);
        s.ovf   = model_ovf;
        s.irq   = model_irq;
        s.check_head = s.ready || zero_head;
        s.data  = s.ready ? model_q[0].data : '0;
        s.flg   = s.ready ? model_q[0].flg  : '0;
        exp_q.push_back(s);
    endtask

    // Monitor: compares the DUT against each queued snapshot mid-cycle.
    initial begin
        snap_t s;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                checkOutput("ready",    64'(fpu_ready),    64'(s.ready));
                checkOutput("count",    64'(fpu_count),    64'(s.count));
                checkOutput("full",     64'(fpu_full),     64'(s.full));
                checkOutput("overflow", 64'(fpu_overflow), 64'(s.ovf));
                checkOutput("irq",      64'(fpu_irq),      64'(s.irq));
                if (s.check_head) begin
                    checkOutput("head_data",  64'(fpu_output),       64'(s.data));
                    checkOutput("head_flags", 64'(fpu_output_flags), 64'(s.flg));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset, then idle with rd_ack on an empty queue.
        applyStimulus(1, 0, '0, '0, 0, 0, 0);
        applyStimulus(1, 0, '0, '0, 0, 0, 0);
        applyStimulus(0, 0, '0, '0, 1, 0, 0);
        applyStimulus(0, 0, '0, '0, 0, 0, 0);

        // Single push is visible one cycle later.
        applyStimulus(0, 1, 32'h3F800000, 4'h1, 0, 0, 0);
        applyStimulus(0, 0, '0, '0, 1, 0, 0);

        // Fill, overflow with a dropped entry, drain in order.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(0, 1, 32'h1000_0000 + i, FW'(i + 2), 0, 0, 0);
        applyStimulus(0, 1, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(0, 0, '0, '0, 1, 0, 0);
        applyStimulus(0, 0, '0, '0, 1, 0, 1);

        // Full with simultaneous push and pop: no overflow, entry kept.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(0, 1, 32'h2000_0000 + i, FW'(i), 0, 0, 0);
        applyStimulus(0, 1, 32'h40000000, 4'h8, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(0, 0, '0, '0, 1, 0, 0);

        // Interrupt threshold behaviour.
        applyStimulus(0, 1, 32'h11, 4'h1, 0, 1, 0);
        applyStimulus(0, 1, 32'h22, 4'h2, 0, 1, 0);
        applyStimulus(0, 0, '0, '0, 1, 1, 0);
        applyStimulus(0, 0, '0, '0, 1, 1, 0);

        // Reset mid-stream with doorbell high.
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 32'h3000_0000 + i, FW'(i), 0, 1, 0);
        applyStimulus(0, 1, 32'hBAD0BAD0, 4'h3, 1, 1, 1);
        applyStimulus(1, 1, 32'hCAFEF00D, 4'h5, 0, 1, 0);
        applyStimulus(0, 0, '0, '0, 0, 1, 0);

        // Set-wins: fill, then drop and clear in the same cycle.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(0, 1, 32'h5000_0000 + i, FW'(i), 0, 1, 0);
        applyStimulus(0, 1, 32'h5555_5555, 4'h5, 0, 1, 1);
        applyStimulus(0, 0, '0, '0, 0, 1, 1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 49) == 0,
                          $urandom_range(0, 99) < 55,
                          DW'($urandom), FW'($urandom),
                          $urandom_range(0, 99) < 45,
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 9) == 0);
        end

        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain: %0d snapshots unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
